// File: rtl/spill_flush_arbiter_pkg.sv
// Shared types for the spill-register flush arbiter.
package spill_flush_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    FLUSH = 2'd1,
    ACK   = 2'd2
  } state_e;

endpackage

// File: rtl/spill_flush_arbiter_if.sv
// Stream bundle between the requesters, the arbiter and the downstream spill register.
interface spill_flush_arbiter_if #(
  parameter int unsigned NumInp = 4,
  parameter type         T      = logic [31:0]
) ();
  localparam int unsigned IdxWidth = $clog2(NumInp);

  logic [NumInp-1:0]   inp_valid;
  logic [NumInp-1:0]   inp_ready;
  T     [NumInp-1:0]   inp_data;
  logic                oup_valid;
  logic                oup_ready;
  T                    oup_data;
  logic [IdxWidth-1:0] oup_idx;
  logic                oup_flush;

  // Requester/spill-register side: drives inputs, observes the arbiter.
  modport master (
    output inp_valid, inp_data, oup_ready,
    input  inp_ready, oup_valid, oup_data, oup_idx, oup_flush
  );

  // Arbiter side.
  modport slave (
    input  inp_valid, inp_data, oup_ready,
    output inp_ready, oup_valid, oup_data, oup_idx, oup_flush
  );
endinterface

// File: rtl/spill_flush_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after start_i, with wrap-around.
module rr_pick #(
  parameter  int unsigned NumInp   = 4,
  localparam int unsigned IdxWidth = $clog2(NumInp)
) (
  input  logic [NumInp-1:0]   req_i,
  input  logic [IdxWidth-1:0] start_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                any_o
);
  localparam int unsigned SumW = IdxWidth + 1;

  logic [NumInp-1:0]   rot;
  logic [IdxWidth-1:0] first;
  logic [SumW-1:0]     sum;

  // Rotate so start_i lands at bit 0, take the lowest set bit, rotate the result back.
  // Wrap is done against NumInp, not 2^IdxWidth, so odd requester counts stay in range.
  always_comb begin
    rot   = '0;
    first = '0;
    any_o = 1'b0;
    sum   = '0;
    idx_o = start_i;
    for (int unsigned i = 0; i < NumInp; i++) begin
      sum = SumW'(start_i) + SumW'(i);
      if (sum >= SumW'(NumInp)) sum = sum - SumW'(NumInp);
      rot[i] = req_i[sum[IdxWidth-1:0]];
    end
    for (int unsigned i = 0; i < NumInp; i++) begin
      if (!any_o && rot[i]) begin
        any_o = 1'b1;
        first = IdxWidth'(i);
      end
    end
    sum = SumW'(start_i) + SumW'(first);
    if (sum >= SumW'(NumInp)) sum = sum - SumW'(NumInp);
    if (any_o) idx_o = sum[IdxWidth-1:0];
  end

endmodule

// File: rtl/spill_flush_arbiter.sv
// Round-robin arbiter in front of a flushable spill register, with four-phase flush sequencing.
module spill_flush_arbiter
  import spill_flush_arbiter_pkg::*;
#(
  parameter  int unsigned NumInp   = 4,
  parameter  type         T        = logic [31:0],
  localparam int unsigned IdxWidth = $clog2(NumInp)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  spill_flush_arbiter_if.slave        bus,
  input  logic                        flush_req_i,
  output logic                        flush_ack_o,
  output logic                        busy_o
);

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] rr_q, rr_d, idx_q, idx_d;
  logic                lock_q, lock_d;
  logic                flush_q, ack_q, busy_q;

  logic [IdxWidth-1:0] pick_idx, grant, grant_inc;
  logic                pick_any, valid_sel, in_arb, flush_now, oup_valid, hs;
  logic [NumInp-1:0]   ready;
  T                    data_sel;

  rr_pick #(.NumInp(NumInp)) i_pick (
    .req_i   (bus.inp_valid),
    .start_i (rr_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Grant selection and the zero-latency handshake path.
  // A held (locked) transfer blocks a flush start; outputs are forced low while in reset.
  always_comb begin
    grant     = lock_q ? idx_q : pick_idx;
    valid_sel = lock_q ? bus.inp_valid[idx_q] : pick_any;
    in_arb    = (state_q == ARB);
    flush_now = in_arb & flush_req_i & ~lock_q;
    oup_valid = rst_ni & in_arb & ~flush_now & valid_sel;
    hs        = oup_valid & bus.oup_ready;
    grant_inc = (grant == IdxWidth'(NumInp - 1)) ? '0 : grant + 1'b1;
    data_sel  = bus.inp_data[grant];
    ready     = '0;
    if (rst_ni && in_arb && !flush_now) ready[grant] = bus.oup_ready;
  end

  assign bus.oup_valid = oup_valid;
  assign bus.inp_ready = ready;
  assign bus.oup_data  = data_sel;
  assign bus.oup_idx   = grant;
  assign bus.oup_flush = flush_q;
  assign flush_ack_o   = ack_q;
  assign busy_o        = busy_q;

  // Next state: a locked transfer that completes alongside a flush request goes straight to FLUSH.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    lock_d  = lock_q;
    idx_d   = idx_q;
    unique case (state_q)
      ARB: begin
        if (hs) begin
          rr_d   = grant_inc;
          lock_d = 1'b0;
        end else if (oup_valid) begin
          lock_d = 1'b1;
          idx_d  = grant;
        end
        if (flush_req_i && (!lock_q || hs)) state_d = FLUSH;
      end
      FLUSH: begin
        rr_d    = '0;
        lock_d  = 1'b0;
        state_d = ACK;
      end
      ACK: begin
        if (!flush_req_i) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // State and registered flush/ack/busy outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB;
      rr_q    <= '0;
      idx_q   <= '0;
      lock_q  <= 1'b0;
      flush_q <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      idx_q   <= idx_d;
      lock_q  <= lock_d;
      flush_q <= (state_d == FLUSH);
      ack_q   <= (state_d == ACK);
      busy_q  <= (state_d != ARB);
    end
  end

endmodule

// File: tb/tb_spill_flush_arbiter.sv
// Bench for spill_flush_arbiter: a 4-input and a 3-input instance against a behavioural model.
module tb_spill_flush_arbiter;

  localparam int P_ARB = 0;
  localparam int P_FL  = 1;
  localparam int P_ACK = 2;

  typedef struct packed {
    int rr;
    bit locked;
    int lidx;
    int phase;
  } ms_t;

  typedef struct packed {
    bit       valid;
    bit [3:0] ready;
    int       idx;
    bit       flush;
    bit       ack;
    bit       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spill_flush_arbiter_if #(.NumInp(4), .T(logic [31:0])) bus4 ();
  spill_flush_arbiter_if #(.NumInp(3), .T(logic [31:0])) bus3 ();
  logic freq4, freq3, ack4, ack3, busy4, busy3;

  spill_flush_arbiter #(.NumInp(4), .T(logic [31:0])) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus4),
    .flush_req_i(freq4), .flush_ack_o(ack4), .busy_o(busy4)
  );
  spill_flush_arbiter #(.NumInp(3), .T(logic [31:0])) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus3),
    .flush_req_i(freq3), .flush_ack_o(ack3), .busy_o(busy3)
  );

  int n_cmp = 0;
  int n_err = 0;
  ms_t s4, s3;
  logic [3:0] hs4;
  logic [2:0] hs3;
  int o4_idx, o3_idx;
  bit o4_valid, o4_flush, o4_ack;

  function automatic ms_t ms_reset();
    ms_t r;
    r.rr = 0; r.locked = 1'b0; r.lidx = 0; r.phase = P_ARB;
    return r;
  endfunction

  // Spec-level model: grant = first valid index scanning from rr with wrap-around.
  function automatic void model(input int n, input logic rst, input ms_t s, input logic [3:0] v,
                                input logic rdy, input logic fr, output exp_t e, output ms_t nx);
    int g;
    bit found;
    nx = s;
    e = '0;
    e.flush = (s.phase == P_FL);
    e.ack   = (s.phase == P_ACK);
    e.busy  = (s.phase != P_ARB);
    g = s.rr;
    found = 1'b0;
    if (s.locked) g = s.lidx;
    else
      for (int k = 0; k < n; k++)
        if (!found && v[(s.rr + k) % n]) begin
          found = 1'b1;
          g = (s.rr + k) % n;
        end
    e.idx = g;
    if (s.phase == P_ARB) begin
      if (fr && !s.locked) nx.phase = P_FL;
      else begin
        e.valid = v[g];
        e.ready[g] = rdy;
        if (e.valid && rdy) begin
          nx.rr = (g + 1) % n;
          nx.locked = 1'b0;
          if (fr) nx.phase = P_FL;
        end else if (e.valid) begin
          nx.locked = 1'b1;
          nx.lidx = g;
        end
      end
    end else if (s.phase == P_FL) begin
      nx.phase = P_ACK;
      nx.rr = 0;
      nx.locked = 1'b0;
    end else if (!fr) nx.phase = P_ARB;
    if (!rst) begin
      e.valid = 1'b0;
      e.ready = '0;
    end
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check both instances mid-cycle, then advance the model past the edge.
  task automatic tick();
    exp_t e4, e3;
    ms_t x4, x3;
    @(negedge clk);
    model(4, rst_n, s4, bus4.inp_valid, bus4.oup_ready, freq4, e4, x4);
    model(3, rst_n, s3, {1'b0, bus3.inp_valid}, bus3.oup_ready, freq3, e3, x3);
    cmp("d4.valid", bus4.oup_valid, e4.valid);
    cmp("d4.ready", bus4.inp_ready, e4.ready);
    cmp("d4.idx",   bus4.oup_idx, e4.idx);
    cmp("d4.data",  bus4.oup_data, bus4.inp_data[e4.idx]);
    cmp("d4.flush", bus4.oup_flush, e4.flush);
    cmp("d4.ack",   ack4, e4.ack);
    cmp("d4.busy",  busy4, e4.busy);
    cmp("d3.valid", bus3.oup_valid, e3.valid);
    cmp("d3.ready", bus3.inp_ready, e3.ready[2:0]);
    cmp("d3.idx",   bus3.oup_idx, e3.idx);
    cmp("d3.data",  bus3.oup_data, bus3.inp_data[e3.idx]);
    cmp("d3.flush", bus3.oup_flush, e3.flush);
    cmp("d3.ack",   ack3, e3.ack);
    cmp("d3.busy",  busy3, e3.busy);
    cmp("d4.flush_and_valid", bus4.oup_flush & bus4.oup_valid, 1'b0);
    hs4 = e4.ready & bus4.inp_valid;
    hs3 = e3.ready[2:0] & bus3.inp_valid;
    o4_valid = bus4.oup_valid;
    o4_flush = bus4.oup_flush;
    o4_ack   = ack4;
    o4_idx   = int'(bus4.oup_idx);
    o3_idx   = int'(bus3.oup_idx);
    @(posedge clk);
    #1;
    if (rst_n) begin
      s4 = x4;
      s3 = x3;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop without waiting for a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    s4 = ms_reset();
    s3 = ms_reset();
    cmp("rst.valid", bus4.oup_valid, 1'b0);
    cmp("rst.ready", bus4.inp_ready, 4'b0);
    cmp("rst.busy",  busy4, 1'b0);
    cmp("rst.flush", bus4.oup_flush, 1'b0);
    cmp("rst.ack",   ack4, 1'b0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic rand_drive();
    for (int i = 0; i < 4; i++)
      if (hs4[i] || !bus4.inp_valid[i]) begin
        bus4.inp_valid[i] = ($urandom_range(0, 99) < 45);
        bus4.inp_data[i]  = $urandom;
      end
    for (int i = 0; i < 3; i++)
      if (hs3[i] || !bus3.inp_valid[i]) begin
        bus3.inp_valid[i] = ($urandom_range(0, 99) < 55);
        bus3.inp_data[i]  = $urandom;
      end
    bus4.oup_ready = ($urandom_range(0, 99) < 60);
    bus3.oup_ready = ($urandom_range(0, 99) < 50);
    if (!freq4) begin
      if (s4.phase != P_ACK && $urandom_range(0, 99) < 6) freq4 = 1'b1;
    end else if (s4.phase == P_ACK && $urandom_range(0, 99) < 50) freq4 = 1'b0;
    if (!freq3) begin
      if (s3.phase != P_ACK && $urandom_range(0, 99) < 6) freq3 = 1'b1;
    end else if (s3.phase == P_ACK && $urandom_range(0, 99) < 50) freq3 = 1'b0;
  endtask

  initial begin
    int rr_exp[5] = '{0, 1, 2, 3, 0};
    int alt_exp[4] = '{2, 0, 2, 0};
    bit fl_exp[6] = '{0, 1, 0, 0, 0, 0};
    bit ak_exp[6] = '{0, 0, 1, 1, 1, 0};
    bit vl_exp[6] = '{0, 0, 0, 0, 0, 1};
    bit dv_exp[5] = '{1, 1, 1, 1, 0};
    bit df_exp[5] = '{0, 0, 0, 0, 1};

    bus4.inp_valid = '0;
    bus4.oup_ready = 1'b0;
    bus3.inp_valid = '0;
    bus3.oup_ready = 1'b0;
    freq4 = 1'b0;
    freq3 = 1'b0;
    hs4 = '0;
    hs3 = '0;
    for (int i = 0; i < 4; i++) bus4.inp_data[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 3; i++) bus3.inp_data[i] = 32'hB000_0000 + 32'(i);
    do_reset();

    // Round-robin with all requesters valid and a always-ready sink.
    bus4.inp_valid = 4'b1111;
    bus4.oup_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      cmp("rr.seq", o4_idx, rr_exp[k]);
      cmp("rr.valid", o4_valid, 1'b1);
    end
    bus4.inp_valid = '0;

    // Lock: requester 2 stalled three cycles, requester 0 arrives meanwhile.
    do_reset();
    bus4.inp_valid = 4'b0100;
    bus4.oup_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) bus4.inp_valid[0] = 1'b1;
      if (k == 3) bus4.oup_ready = 1'b1;
      tick();
      cmp("lock.idx", o4_idx, 2);
    end
    bus4.inp_valid[2] = 1'b0;
    tick();
    cmp("lock.wrap_idx", o4_idx, 0);
    bus4.inp_valid = '0;

    // Flush from idle after moving rr off zero; held valids must not leak during the flush.
    do_reset();
    bus4.inp_valid = 4'b0010;
    bus4.oup_ready = 1'b1;
    tick();
    bus4.inp_valid = 4'b1010;
    freq4 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) freq4 = 1'b0;
      tick();
      cmp("fidle.flush", o4_flush, fl_exp[k]);
      cmp("fidle.ack", o4_ack, ak_exp[k]);
      cmp("fidle.valid", o4_valid, vl_exp[k]);
    end
    cmp("fidle.restart_idx", o4_idx, 1);
    bus4.inp_valid = '0;

    // Deferred flush behind a locked transfer.
    do_reset();
    bus4.inp_valid = 4'b0010;
    bus4.oup_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) freq4 = 1'b1;
      if (k == 3) bus4.oup_ready = 1'b1;
      if (k == 4) bus4.inp_valid[1] = 1'b0;
      tick();
      cmp("fdef.valid", o4_valid, dv_exp[k]);
      cmp("fdef.flush", o4_flush, df_exp[k]);
    end
    tick();
    cmp("fdef.ack", o4_ack, 1'b1);
    freq4 = 1'b0;
    tick();
    tick();

    // Non-power-of-two instance: inputs 2 and 0 alternate.
    do_reset();
    bus3.inp_valid = 3'b001;
    bus3.oup_ready = 1'b1;
    tick();
    bus3.inp_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      tick();
      cmp("np2.seq", o3_idx, alt_exp[k]);
    end
    bus3.inp_valid = '0;
    tick();
    cmp("np2.idle_idx", o3_idx, 1);

    // Reset while locked, then first grant is the lowest valid index.
    bus4.inp_valid = 4'b0100;
    bus4.oup_ready = 1'b0;
    tick();
    bus4.inp_valid = 4'b0101;
    tick();
    cmp("rlock.idx", o4_idx, 2);
    do_reset();
    tick();
    cmp("rlock.after_idx", o4_idx, 0);
    cmp("rlock.after_valid", o4_valid, 1'b1);
    bus4.oup_ready = 1'b1;
    tick();
    bus4.inp_valid = '0;
    hs4 = '0;
    hs3 = '0;

    // Randomized traffic on both instances, with one asynchronous reset in the middle.
    for (int c = 0; c < 500; c++) begin
      if (c == 250) do_reset();
      rand_drive();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
